// File: rtl/adjust_pulse_gen_pkg.sv
// Shared types and default timing for the clock/alarm adjust button front end.
package clock_adjust_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, REPEAT, LOCKOUT} adj_state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} adj_dir_t;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned HOLD_CYCLES_DEF     = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 10_000_000;
    localparam int unsigned PULSE_CYCLES_DEF    = 1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adjust_pulse_gen_if.sv
// Button/enable inputs and count request outputs between the board and the digit counters.
interface adjust_pulse_if;

    logic btn_up;
    logic btn_down;
    logic en;
    logic count_up;
    logic count_down;
    logic busy;

    modport master (
        output btn_up,
        output btn_down,
        output en,
        input  count_up,
        input  count_down,
        input  busy
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  en,
        output count_up,
        output count_down,
        output busy
    );

endinterface

// File: rtl/adjust_pulse_gen_debounce.sv
// Synchroniser plus consecutive-sample debouncer; emits the settled level and a one-cycle rise strobe.
module btn_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Any sample equal to the current level restarts the count, so glitches never accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            rise_q <= 1'b0;
            if (synced == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= synced;
                rise_q  <= synced;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/adjust_pulse_gen.sv
// Turns debounced up/down buttons into count_up/count_down request pulses for the digit counters.
// Auto-repeat while held is built only when ADJUST_AUTO_REPEAT_EN is defined.
module adjust_pulse_gen
    import clock_adjust_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    adjust_pulse_if.slave ifc
);

    // state   | meaning
    // IDLE    | waiting for a single debounced press
    // ARMED   | press accepted and pulsed, waiting for release or hold time
    // REPEAT  | auto-repeating in the remembered direction
    // LOCKOUT | both buttons seen together; silent until both released

    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || PULSE_CYCLES < 1 ||
        HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("adjust_pulse_gen: invalid timing parameters");
    end

    logic up_lvl, up_rise, dn_lvl, dn_rise;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (ifc.btn_up),
        .level_o (up_lvl),
        .rise_o  (up_rise)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (ifc.btn_down),
        .level_o (dn_lvl),
        .rise_o  (dn_rise)
    );

    adj_state_t    state_q;
    adj_dir_t      dir_q;
    logic          pend_q;
    logic [PW-1:0] pulse_cnt_q;
    logic          up_q;
    logic          dn_q;
    logic          busy_q;

    logic     pulse_idle;
    logic     press_go;
    adj_dir_t press_dir;
    logic     dir_lvl;
    logic     oth_lvl;

`ifdef ADJUST_AUTO_REPEAT_EN
    localparam int unsigned TW = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    logic [TW-1:0] tmr_q;
    logic          tmr_fire;
`endif

    always_comb begin
        pulse_idle = (pulse_cnt_q == '0);
        press_go   = (state_q == IDLE) && !(up_lvl && dn_lvl) && (up_rise || dn_rise);
        press_dir  = up_rise ? DIR_UP : DIR_DOWN;
        dir_lvl    = (dir_q == DIR_UP) ? up_lvl : dn_lvl;
        oth_lvl    = (dir_q == DIR_UP) ? dn_lvl : up_lvl;
`ifdef ADJUST_AUTO_REPEAT_EN
        // A due repeat waits for the previous pulse to finish, giving PULSE_CYCLES+1 minimum spacing.
        tmr_fire   = ((state_q == ARMED) || (state_q == REPEAT)) && dir_lvl && !oth_lvl &&
                     (tmr_q == '0) && pulse_idle && !pend_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_UP;
            pend_q      <= 1'b0;
            pulse_cnt_q <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADJUST_AUTO_REPEAT_EN
            tmr_q       <= '0;
`endif
        end else if (!ifc.en) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            pulse_cnt_q <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADJUST_AUTO_REPEAT_EN
            tmr_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (up_lvl && dn_lvl) begin
                        state_q <= LOCKOUT;
                        busy_q  <= 1'b1;
                    end else if (press_go) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                        dir_q   <= press_dir;
`ifdef ADJUST_AUTO_REPEAT_EN
                        tmr_q   <= TW'(HOLD_CYCLES - 1);
`endif
                    end
                end
                ARMED: begin
                    if (!dir_lvl) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (oth_lvl) begin
                        state_q <= LOCKOUT;
`ifdef ADJUST_AUTO_REPEAT_EN
                    end else if (tmr_fire) begin
                        state_q <= REPEAT;
                        tmr_q   <= TW'(REPEAT_CYCLES - 1);
                    end else if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 1'b1;
`endif
                    end
                end
`ifdef ADJUST_AUTO_REPEAT_EN
                REPEAT: begin
                    if (!dir_lvl) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (oth_lvl) begin
                        state_q <= LOCKOUT;
                    end else if (tmr_fire) begin
                        tmr_q <= TW'(REPEAT_CYCLES - 1);
                    end else if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
`endif
                LOCKOUT: begin
                    if (!up_lvl && !dn_lvl) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A running pulse always completes; a press arriving meanwhile is held pending.
            if (!pulse_idle) begin
                pulse_cnt_q <= pulse_cnt_q - 1'b1;
                if (pulse_cnt_q == PW'(1)) begin
                    up_q <= 1'b0;
                    dn_q <= 1'b0;
                end
                if (press_go) begin
                    pend_q <= 1'b1;
                end
            end else if (press_go) begin
                pulse_cnt_q <= PW'(PULSE_CYCLES);
                up_q        <= (press_dir == DIR_UP);
                dn_q        <= (press_dir == DIR_DOWN);
            end else if (pend_q) begin
                pend_q      <= 1'b0;
                pulse_cnt_q <= PW'(PULSE_CYCLES);
                up_q        <= (dir_q == DIR_UP);
                dn_q        <= (dir_q == DIR_DOWN);
`ifdef ADJUST_AUTO_REPEAT_EN
            end else if (tmr_fire) begin
                pulse_cnt_q <= PW'(PULSE_CYCLES);
                up_q        <= (dir_q == DIR_UP);
                dn_q        <= (dir_q == DIR_DOWN);
`endif
            end
        end
    end

    assign ifc.count_up   = up_q;
    assign ifc.count_down = dn_q;
    assign ifc.busy       = busy_q;

endmodule
